// File: rtl/idli_pkg.sv
// Shared SQI definitions: opcodes, address width and the memory responder state type.
package idli_pkg;

  localparam int         SQI_ADDR_W    = 16;
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// Byte-wide RAM for the SQI responder: one write port, one registered-read port.
module idli_sqi_mem_ram_m #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI (quad-SPI) SRAM responder: command, 16-bit address, dummy turnaround, then read/write stream.
// Optional unknown-opcode sticky flag enabled by defining IDLI_SQI_MEM_CMD_CHK_EN.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst,
  input  logic       i_mem_cs_n,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe,
  output logic       o_mem_bad_cmd
);

  localparam logic [1:0] ADDR_LAST  = 2'(SQI_ADDR_W / 4 - 1);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_NIBBLES - 1);

  sqi_mem_state_t    state_reg, state_next;
  logic [1:0]        ctr_reg, ctr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              phase_reg, phase_next;
  logic [3:0]        hi_reg, hi_next;
  logic              is_wr_reg, is_wr_next;
  logic [3:0]        sio_reg, sio_next;
  logic              oe_reg, oe_next;
  logic              wr_en;
  logic [7:0]        rd_data;
  logic [7:0]        opcode;

  assign opcode = {hi_reg, i_mem_sio};

  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg + 2'd1;
    addr_next  = addr_reg;
    phase_next = phase_reg;
    hi_next    = hi_reg;
    is_wr_next = is_wr_reg;
    sio_next   = sio_reg;
    oe_next    = oe_reg;
    wr_en      = 1'b0;
    if (i_mem_cs_n) begin
      state_next = CMD;
      ctr_next   = 2'd0;
      phase_next = 1'b0;
      sio_next   = 4'h0;
      oe_next    = 1'b0;
    end else begin
      case (state_reg)
        CMD: begin
          if (ctr_reg == 2'd0) begin
            hi_next = i_mem_sio;
          end else begin
            ctr_next = 2'd0;
            if (opcode == SQI_CMD_READ) begin
              is_wr_next = 1'b0;
              state_next = ADDR;
            end else if (opcode == SQI_CMD_WRITE) begin
              is_wr_next = 1'b1;
              state_next = ADDR;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          // Shifting nibbles through the narrow register keeps only the low ADDR_W address bits.
          addr_next = (ctr_reg == 2'd0) ? ADDR_W'(i_mem_sio) : ADDR_W'({addr_reg, i_mem_sio});
          if (ctr_reg == ADDR_LAST) begin
            ctr_next   = 2'd0;
            phase_next = 1'b0;
            state_next = is_wr_reg ? WR : DUMMY;
          end
        end
        DUMMY: begin
          if (ctr_reg == DUMMY_LAST) begin
            state_next = RD;
            oe_next    = 1'b1;
            sio_next   = rd_data[7:4];
            phase_next = 1'b1;
          end
        end
        RD: begin
          if (phase_reg) begin
            sio_next   = rd_data[3:0];
            addr_next  = addr_reg + ADDR_W'(1);
            phase_next = 1'b0;
          end else begin
            sio_next   = rd_data[7:4];
            phase_next = 1'b1;
          end
        end
        WR: begin
          if (!phase_reg) begin
            hi_next    = i_mem_sio;
            phase_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            addr_next  = addr_reg + ADDR_W'(1);
            phase_next = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      state_reg <= CMD;
      ctr_reg   <= 2'd0;
      addr_reg  <= '0;
      phase_reg <= 1'b0;
      hi_reg    <= 4'h0;
      is_wr_reg <= 1'b0;
      sio_reg   <= 4'h0;
      oe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
      addr_reg  <= addr_next;
      phase_reg <= phase_next;
      hi_reg    <= hi_next;
      is_wr_reg <= is_wr_next;
      sio_reg   <= sio_next;
      oe_reg    <= oe_next;
    end
  end

  // Reading at addr_next means rd_data always holds mem[addr_reg] one edge later.
  idli_sqi_mem_ram_m #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (i_mem_gck),
    .we   (wr_en & ~i_mem_rst),
    .waddr(addr_reg),
    .wdata({hi_reg, i_mem_sio}),
    .raddr(addr_next),
    .rdata(rd_data)
  );

  assign o_mem_sio    = sio_reg;
  assign o_mem_sio_oe = oe_reg;

`ifdef IDLI_SQI_MEM_CMD_CHK_EN
  logic bad_reg;

  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      bad_reg <= 1'b0;
    end else if (!i_mem_cs_n && state_reg == CMD && ctr_reg == 2'd1 &&
                 opcode != SQI_CMD_READ && opcode != SQI_CMD_WRITE) begin
      bad_reg <= 1'b1;
    end
  end

  assign o_mem_bad_cmd = bad_reg;
`else
  assign o_mem_bad_cmd = 1'b0;
`endif

endmodule
